// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Bundle between the pipeline and the hazard controller.
//                The pipeline side (master) reports register fields, load,
//                branch and data-memory status. The controller side (slave)
//                returns the stage enables, flush strobes, watchdog flag and
//                performance counters.
//  Revision    : 1.0  initial release
// ============================================================================
interface hazard_ctrl_if;

    // ID-stage source operands
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;

    // EX-stage destination and status
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_branch_taken;

    // MEM-stage data-memory handshake
    logic        dmem_req;
    logic        dmem_ready;

    // Stage enables and flush strobes
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_write;
    logic        id_ex_flush;
    logic        ex_me_write;
    logic        me_wb_flush;

    // Watchdog and performance counters
    logic        mem_timeout;
    logic [15:0] lu_stall_cnt;
    logic [15:0] br_flush_cnt;
    logic [15:0] mem_wait_cnt;

    // Pipeline side: supplies hazard sources and consumes the controls
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rd, ex_mem_read, ex_branch_taken,
        output dmem_req, dmem_ready,
        input  pc_write, if_id_write, if_id_flush,
        input  id_ex_write, id_ex_flush, ex_me_write, me_wb_flush,
        input  mem_timeout, lu_stall_cnt, br_flush_cnt, mem_wait_cnt
    );

    // Controller side: consumes hazard sources and produces the controls
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rd, ex_mem_read, ex_branch_taken,
        input  dmem_req, dmem_ready,
        output pc_write, if_id_write, if_id_flush,
        output id_ex_write, id_ex_flush, ex_me_write, me_wb_flush,
        output mem_timeout, lu_stall_cnt, br_flush_cnt, mem_wait_cnt
    );

endinterface : hazard_ctrl_if
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard and stall controller for the 5-stage core.
//                Resolves data-memory freezes, taken-branch flushes and
//                load-use stalls (priority in that order). It drives the
//                stage enables and flush strobes combinationally and runs a
//                RUN/WAIT FSM with a sticky wait-timeout watchdog.
//  Options     : `define HAZARD_PERF_EN to build the three saturating 16-bit
//                performance counters; otherwise the counter ports read 0.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int WAIT_W      = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0]        c_st_run   = 1'b0;
    localparam logic [0:0]        c_st_wait  = 1'b1;
    localparam logic [WAIT_W-1:0] c_wait_max = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] c_wait_one = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] c_timeout  = WAIT_W'(MEM_TIMEOUT);

    // ------------------------------------------------------------------------
    // Hazard conditions
    // ------------------------------------------------------------------------
    logic w_freeze;
    logic w_branch;
    logic w_load_use;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // A load into x0 never creates a dependency, and an operand that the ID
    // instruction does not read cannot create one either.
    assign w_rs1_hit  = hz.id_use_rs1 && (hz.ex_rd == hz.id_rs1);
    assign w_rs2_hit  = hz.id_use_rs2 && (hz.ex_rd == hz.id_rs2);
    assign w_load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);
    assign w_freeze   = hz.dmem_req && !hz.dmem_ready;
    assign w_branch   = hz.ex_branch_taken;

    // ------------------------------------------------------------------------
    // Memory-wait FSM
    // ------------------------------------------------------------------------
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_cnt_nxt;
    logic              w_timeout_hit;
    logic              r_mem_timeout;

    // State register; reset aborts any wait in progress immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: enter WAIT on a freeze, leave once memory completes or the
    // request is withdrawn
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_run: begin
                if (w_freeze) begin
                    w_state_nxt = c_st_wait;
                end
            end
            c_st_wait: begin
                if (hz.dmem_ready || !hz.dmem_req) begin
                    w_state_nxt = c_st_run;
                end
            end
            default: begin
                w_state_nxt = c_st_run;
            end
        endcase
    end

    // Stage controls; reset forces every stage to hold and load bubbles
    always_comb begin
        hz.pc_write    = 1'b1;
        hz.if_id_write = 1'b1;
        hz.if_id_flush = 1'b0;
        hz.id_ex_write = 1'b1;
        hz.id_ex_flush = 1'b0;
        hz.ex_me_write = 1'b1;
        hz.me_wb_flush = 1'b0;
        if (rst) begin
            hz.pc_write    = 1'b0;
            hz.if_id_write = 1'b0;
            hz.if_id_flush = 1'b1;
            hz.id_ex_write = 1'b0;
            hz.id_ex_flush = 1'b1;
            hz.ex_me_write = 1'b0;
            hz.me_wb_flush = 1'b1;
        end else if (w_freeze) begin
            // Everything up to EX/MEM holds; WB must not retire the stalled
            // MEM instruction twice, so MEM/WB takes a bubble.
            hz.pc_write    = 1'b0;
            hz.if_id_write = 1'b0;
            hz.id_ex_write = 1'b0;
            hz.ex_me_write = 1'b0;
            hz.me_wb_flush = 1'b1;
        end else if (w_branch) begin
            // Wrong-path IF and ID instructions are discarded, which also
            // makes any load-use dependency of the ID instruction moot.
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            // Hold PC and IF/ID for one cycle and push a bubble into EX.
            hz.pc_write    = 1'b0;
            hz.if_id_write = 1'b0;
            hz.id_ex_flush = 1'b1;
        end
    end

    // Wait counter next value: counts while the FSM stays in WAIT,
    // saturating, and returns to zero on leaving WAIT
    always_comb begin
        w_wait_cnt_nxt = '0;
        if ((r_state == c_st_wait) && (w_state_nxt == c_st_wait)) begin
            if (r_wait_cnt != c_wait_max) begin
                w_wait_cnt_nxt = r_wait_cnt + c_wait_one;
            end else begin
                w_wait_cnt_nxt = r_wait_cnt;
            end
        end
    end

    // The watchdog fires on the edge at which the counter reaches the limit
    assign w_timeout_hit = (r_state == c_st_wait) && (w_state_nxt == c_st_wait) &&
                           (w_wait_cnt_nxt == c_timeout);

    // Wait counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Sticky timeout flag; only reset clears it, the pipeline keeps stalling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_timeout <= 1'b0;
        end else if (w_timeout_hit) begin
            r_mem_timeout <= 1'b1;
        end
    end

    assign hz.mem_timeout = r_mem_timeout;

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    logic        w_do_branch;
    logic        w_do_load_use;
    logic [15:0] r_lu_stall_cnt;
    logic [15:0] r_br_flush_cnt;
    logic [15:0] r_mem_wait_cnt;

    // Count the action actually taken, not merely the raw condition
    assign w_do_branch   = w_branch && !w_freeze;
    assign w_do_load_use = w_load_use && !w_branch && !w_freeze;

    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lu_stall_cnt <= 16'd0;
            r_br_flush_cnt <= 16'd0;
            r_mem_wait_cnt <= 16'd0;
        end else begin
            if (w_do_load_use && (r_lu_stall_cnt != c_cnt_max)) begin
                r_lu_stall_cnt <= r_lu_stall_cnt + 16'd1;
            end
            if (w_do_branch && (r_br_flush_cnt != c_cnt_max)) begin
                r_br_flush_cnt <= r_br_flush_cnt + 16'd1;
            end
            if (w_freeze && (r_mem_wait_cnt != c_cnt_max)) begin
                r_mem_wait_cnt <= r_mem_wait_cnt + 16'd1;
            end
        end
    end

    assign hz.lu_stall_cnt = r_lu_stall_cnt;
    assign hz.br_flush_cnt = r_br_flush_cnt;
    assign hz.mem_wait_cnt = r_mem_wait_cnt;
`else
    assign hz.lu_stall_cnt = 16'd0;
    assign hz.br_flush_cnt = 16'd0;
    assign hz.mem_wait_cnt = 16'd0;
`endif

endmodule : hazard_ctrl
`default_nettype wire
